// File: rtl/uram_pkg.sv
// Shared types, defaults and helpers for the UltraRAM arbiter slice.
package uram_pkg;

    localparam int URAM_ADDR_W = 10;
    localparam int URAM_DATA_W = 2048;
    localparam int SLICE_MAX_N = 8;
    localparam int SLICE_MAX_W = 32;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_t;

    // Extracts field idx of width w from a zero-extended packed vector.
    function automatic logic [SLICE_MAX_W-1:0] addr_slice(
        input logic [SLICE_MAX_N*SLICE_MAX_W-1:0] packed_v,
        input int idx,
        input int w
    );
        logic [SLICE_MAX_N*SLICE_MAX_W-1:0] sh;
        logic [SLICE_MAX_W-1:0] mask;
        sh   = packed_v >> (idx * w);
        mask = {SLICE_MAX_W{1'b1}} >> (SLICE_MAX_W - w);
        return sh[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/uram_arbiter_rr_picker.sv
// Combinational round-robin search: first valid at or after ptr,
// wrapping to the lowest valid index.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 3
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          hi_found;
    logic          lo_found;

    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i] && (IW'(i) >= ptr)) begin
                hi_idx   = IW'(i);
                hi_found = 1'b1;
            end
            if (valid[i]) begin
                lo_idx   = IW'(i);
                lo_found = 1'b1;
            end
        end
    end

    always_comb begin
        idx   = hi_found ? hi_idx : lo_idx;
        found = lo_found;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/uram_arbiter.sv
// Shares one UltraRAM between N_REQ readers and one writer.
// Define UARB_STATS_EN to add grant/conflict counters.
module uram_arbiter
    import uram_pkg::*;
#(
    parameter int ADDR_WIDTH = URAM_ADDR_W,
    parameter int DATA_WIDTH = URAM_DATA_W,
    parameter int N_REQ      = 2,
    parameter int ID_W       = 3
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef UARB_STATS_EN
    input  logic                      stat_clear,
    output logic [31:0]               stat_grants,
    output logic [31:0]               stat_conflicts,
`endif
    input  logic [N_REQ-1:0]          rd_req_valid,
    output logic [N_REQ-1:0]          rd_req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [N_REQ-1:0]          rd_req_half,
    output logic                      rd_resp_valid,
    output logic [ID_W-1:0]           rd_resp_id,
    output logic [DATA_WIDTH/2-1:0]   rd_resp_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      uram_mem_en,
    output logic                      uram_wr_en,
    output logic [ADDR_WIDTH-1:0]     uram_write_addr,
    output logic [DATA_WIDTH-1:0]     uram_data_in,
    output logic [ADDR_WIDTH-1:0]     uram_read_addr,
    output logic                      uram_read_r_bit,
    input  logic [DATA_WIDTH/2-1:0]   uram_data_out
);

    localparam int EXT_W = SLICE_MAX_N * SLICE_MAX_W;

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       ptr_next;
    logic [ID_W-1:0]       cand_idx;
    logic [N_REQ-1:0]      cand_oh;
    logic                  cand_found;
    logic [EXT_W-1:0]      addr_ext;
    logic [ADDR_WIDTH-1:0] cand_addr;
    half_t                 cand_half;
    logic                  collide;
    logic                  rd_gnt;
    logic                  wr_acc;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [ADDR_WIDTH-1:0] held_addr;
    half_t                 held_half;

    rr_picker #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_pick (
        .valid (rd_req_valid),
        .ptr   (rr_ptr),
        .grant (cand_oh),
        .idx   (cand_idx),
        .found (cand_found)
    );

    always_comb begin
        addr_ext = '0;
        addr_ext[N_REQ*ADDR_WIDTH-1:0] = rd_req_addr;
        cand_addr = ADDR_WIDTH'(
            addr_slice(addr_ext, int'(cand_idx), ADDR_WIDTH));
        cand_half = HALF_LO;
        for (int i = 0; i < N_REQ; i++) begin
            if (cand_oh[i]) cand_half = half_t'(rd_req_half[i]);
        end
    end

    // A same-address write would be missed by the read port this cycle.
    assign collide = cand_found && wr_valid && (cand_addr == wr_addr);
    assign rd_gnt  = cand_found && !collide && !rst;
    assign wr_acc  = wr_valid && !rst;

    assign ptr_next = (cand_idx == ID_W'(N_REQ - 1)) ?
                      '0 : cand_idx + ID_W'(1);

    assign rd_req_ready    = rd_gnt ? cand_oh : '0;
    assign wr_ready        = wr_acc;
    assign uram_wr_en      = wr_acc;
    assign uram_mem_en     = wr_acc || rd_gnt;
    assign uram_write_addr = wr_addr;
    assign uram_data_in    = wr_data;
    assign uram_read_addr  = rd_gnt ? cand_addr : held_addr;
    assign uram_read_r_bit = rd_gnt ? cand_half : held_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            held_addr  <= '0;
            held_half  <= HALF_LO;
        end else begin
            resp_valid <= rd_gnt;
            if (rd_gnt) begin
                rr_ptr    <= ptr_next;
                resp_id   <= cand_idx;
                held_addr <= cand_addr;
                held_half <= cand_half;
            end
        end
    end

    assign rd_resp_valid = resp_valid && !rst;
    assign rd_resp_id    = resp_id;
    assign rd_resp_data  = uram_data_out;

`ifdef UARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            if (rd_gnt && (stat_grants != '1))
                stat_grants <= stat_grants + 32'd1;
            if (collide && (stat_conflicts != '1))
                stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uram_arbiter.sv
// Directed bench for uram_arbiter with a cycle model and a URAM stand-in.
// Define UARB_STATS_EN to also check the statistics counters.
module tb_uram_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 2048;
    localparam int HW  = DW / 2;
    localparam int N   = 2;
    localparam int IDW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    rd_req_valid;
    logic [N-1:0]    rd_req_ready;
    logic [N*AW-1:0] rd_req_addr;
    logic [N-1:0]    rd_req_half;
    logic            rd_resp_valid;
    logic [IDW-1:0]  rd_resp_id;
    logic [HW-1:0]   rd_resp_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            uram_mem_en;
    logic            uram_wr_en;
    logic [AW-1:0]   uram_write_addr;
    logic [DW-1:0]   uram_data_in;
    logic [AW-1:0]   uram_read_addr;
    logic            uram_read_r_bit;
    logic [HW-1:0]   uram_data_out;
`ifdef UARB_STATS_EN
    logic            stat_clear;
    logic [31:0]     stat_grants;
    logic [31:0]     stat_conflicts;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .ID_W       (IDW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef UARB_STATS_EN
        .stat_clear      (stat_clear),
        .stat_grants     (stat_grants),
        .stat_conflicts  (stat_conflicts),
`endif
        .rd_req_valid    (rd_req_valid),
        .rd_req_ready    (rd_req_ready),
        .rd_req_addr     (rd_req_addr),
        .rd_req_half     (rd_req_half),
        .rd_resp_valid   (rd_resp_valid),
        .rd_resp_id      (rd_resp_id),
        .rd_resp_data    (rd_resp_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .uram_mem_en     (uram_mem_en),
        .uram_wr_en      (uram_wr_en),
        .uram_write_addr (uram_write_addr),
        .uram_data_in    (uram_data_in),
        .uram_read_addr  (uram_read_addr),
        .uram_read_r_bit (uram_read_r_bit),
        .uram_data_out   (uram_data_out)
    );

    // URAM stand-in: read returns the pre-write contents.
    logic [DW-1:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        uram_data_out = '0;
    end
    always @(posedge clk) begin
        if (uram_mem_en) begin
            uram_data_out <= uram_read_r_bit ?
                mem[uram_read_addr][DW-1:HW] :
                mem[uram_read_addr][HW-1:0];
            if (uram_wr_en) mem[uram_write_addr] <= uram_data_in;
        end
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chkd(input string nm,
                        input logic [HW-1:0] act,
                        input logic [HW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ..%0h want ..%0h",
                      nm, act[63:0], exp[63:0]);
    endtask

    function automatic logic [HW-1:0] hw(input logic [31:0] w);
        return {32{w}};
    endfunction

    // Behavioural model state
    int            m_ptr = 0;
    bit            m_pend = 0;
    int            m_pid = 0;
    logic [HW-1:0] m_pdata;
    bit            m_held_ok = 0;
    int            m_held_a = 0;
    bit            m_held_h = 0;
    logic [DW-1:0] shadow [int];

    always @(negedge clk) begin : model
        int            cand;
        int            p;
        int            ca;
        bit            ch;
        bit            gnt;
        logic [N-1:0]  er;
        logic [DW-1:0] word;
        cand = -1;
        ca   = 0;
        ch   = 0;
        gnt  = 0;
        er   = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (cand < 0 && rd_req_valid[p]) cand = p;
            end
            if (cand >= 0) begin
                ca  = int'(rd_req_addr[cand*AW +: AW]);
                ch  = rd_req_half[cand];
                gnt = !(wr_valid && ca == int'(wr_addr));
            end
            if (gnt) er[cand] = 1'b1;
        end
        chk("m_ready", rd_req_ready, er);
        chk("m_wr_ready", wr_ready, wr_valid && !rst);
        chk("m_wr_en", uram_wr_en, wr_valid && !rst);
        chk("m_mem_en", uram_mem_en, !rst && (wr_valid || gnt));
        chk("m_resp_valid", rd_resp_valid, m_pend && !rst);
        if (m_pend && !rst) begin
            chk("m_resp_id", rd_resp_id, m_pid);
            chkd("m_resp_data", rd_resp_data, m_pdata);
        end
        if (gnt) begin
            chk("m_rd_addr", uram_read_addr, ca);
            chk("m_rd_half", uram_read_r_bit, ch);
        end else if (m_held_ok && !rst) begin
            chk("m_hold_addr", uram_read_addr, m_held_a);
            chk("m_hold_half", uram_read_r_bit, m_held_h);
        end
        if (rst) begin
            m_ptr     = 0;
            m_pend    = 0;
            m_held_ok = 1;
            m_held_a  = 0;
            m_held_h  = 0;
        end else begin
            m_pend = gnt;
            if (gnt) begin
                word     = shadow.exists(ca) ? shadow[ca] : '0;
                m_pdata  = ch ? word[DW-1:HW] : word[HW-1:0];
                m_pid    = cand;
                m_ptr    = (cand + 1) % N;
                m_held_a = ca;
                m_held_h = ch;
            end
            if (wr_valid) shadow[int'(wr_addr)] = wr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input bit v,
                          input int a, input bit h);
        rd_req_valid[i]        = v;
        rd_req_addr[i*AW +: AW] = AW'(a);
        rd_req_half[i]         = h;
    endtask

    int g0, g1, r0, r1;

    initial begin
        rst          = 1'b1;
        rd_req_valid = '0;
        rd_req_addr  = '0;
        rd_req_half  = '0;
        wr_valid     = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
`ifdef UARB_STATS_EN
        stat_clear   = 1'b0;
`endif
        step();
        set_rd(0, 1, 1, 0);
        set_rd(1, 1, 2, 0);
        wr_valid = 1'b1;
        wr_addr  = 10'd9;
        #5;
        chk("rst_ready", rd_req_ready, 0);
        chk("rst_mem_en", uram_mem_en, 0);
        chk("rst_resp", rd_resp_valid, 0);
        step();
        step();
        set_rd(0, 0, 0, 0);
        set_rd(1, 0, 0, 0);
        wr_valid = 1'b0;
        rst      = 1'b0;
        step();

        // single reader after a write
        wr_valid = 1'b1;
        wr_addr  = 10'd5;
        wr_data  = {hw(32'hA0A0_0001), hw(32'hB0B0_0002)};
        step();
        wr_valid = 1'b0;
        set_rd(0, 1, 5, 1);
        #5;
        chk("t1_ready", rd_req_ready, 2'b01);
        step();
        set_rd(0, 0, 5, 1);
        #5;
        chk("t1_resp_v", rd_resp_valid, 1);
        chk("t1_resp_id", rd_resp_id, 0);
        chkd("t1_resp_d", rd_resp_data, hw(32'hA0A0_0001));
        step();

        // fairness
        g0 = 0; g1 = 0; r0 = 0; r1 = 0;
        for (int k = 0; k < 9; k++) begin
            set_rd(0, k < 8, 10, 0);
            set_rd(1, k < 8, 11, 1);
            #5;
            if (k == 0) chk("fair_first", rd_req_ready, 2'b10);
            g0 += int'(rd_req_ready[0]);
            g1 += int'(rd_req_ready[1]);
            if (rd_resp_valid && rd_resp_id == 0) r0++;
            if (rd_resp_valid && rd_resp_id == 1) r1++;
            step();
        end
        chk("fair_g0", g0, 4);
        chk("fair_g1", g1, 4);
        chk("fair_r0", r0, 4);
        chk("fair_r1", r1, 4);

        // collision
        wr_valid = 1'b1;
        wr_addr  = 10'd7;
        wr_data  = {hw(32'hC0C0_0003), hw(32'hD0D0_0004)};
        set_rd(1, 1, 7, 0);
        #5;
        chk("col_ready0", rd_req_ready, 0);
        chk("col_mem_en", uram_mem_en, 1);
        step();
        wr_valid = 1'b0;
        #5;
        chk("col_ready1", rd_req_ready, 2'b10);
        step();
        set_rd(1, 0, 7, 0);
        #5;
        chk("col_resp_id", rd_resp_id, 1);
        chkd("col_resp_d", rd_resp_data, hw(32'hD0D0_0004));
`ifdef UARB_STATS_EN
        chk("stat_conf", stat_conflicts, 1);
        chk("stat_gnt", stat_grants, 10);
`endif
        step();

        // concurrent non-colliding
        wr_valid = 1'b1;
        wr_addr  = 10'd3;
        wr_data  = {hw(32'h1111_1111), hw(32'h2222_2222)};
        set_rd(0, 1, 4, 1);
        #5;
        chk("cc_ready", rd_req_ready, 2'b01);
        chk("cc_wr_ready", wr_ready, 1);
        chk("cc_mem_en", uram_mem_en, 1);
        chk("cc_wr_en", uram_wr_en, 1);
        step();
        wr_valid = 1'b0;
        set_rd(0, 0, 4, 1);
        #5;
        chk("cc_resp_v", rd_resp_valid, 1);
        chkd("cc_resp_d", rd_resp_data, '0);
        step();

        // reset mid-operation
        set_rd(0, 1, 20, 0);
        set_rd(1, 1, 21, 1);
        #5;
        chk("rm_ready", rd_req_ready, 2'b10);
        step();
        rst = 1'b1;
        #5;
        chk("rm_resp_v", rd_resp_valid, 0);
        step();
        rst = 1'b0;
        #5;
        chk("rm_next", rd_req_ready, 2'b01);
        step();
        set_rd(0, 0, 20, 0);
        set_rd(1, 0, 21, 1);
        step();

        // idle
        for (int k = 0; k < 5; k++) begin
            #5;
            chk("idle_mem_en", uram_mem_en, 0);
            chk("idle_resp_v", rd_resp_valid, 0);
            step();
        end

`ifdef UARB_STATS_EN
        chk("stat_gnt_rst", stat_grants, 1);
        chk("stat_conf_rst", stat_conflicts, 0);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        #5;
        chk("stat_clr", stat_grants, 0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
